// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage MIPS core: load-use and
// branch-operand stalls, jump/branch redirect flush, and data-memory freeze.
module hazard_ctrl #(
  parameter int CNT_W    = 16,
  parameter int WAIT_MAX = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_is_branch,
  input  logic             id_branch_taken,
  input  logic             id_jump,
  input  logic             ex_memRead,
  input  logic             ex_regWrite,
  input  logic [4:0]       ex_dst,
  input  logic             mem_memRead,
  input  logic [4:0]       mem_dst,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             pipe_freeze,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] freeze_cnt,
  output logic             err_timeout
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1
  } state_t;

  localparam int WW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [WW-1:0] WAIT_TOP  = WW'(WAIT_MAX);
  localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_MAX - 1);

  state_t        state_q, state_d;
  logic [WW-1:0] wait_cnt;
  logic          ex_match, mem_match;
  logic          hz, fz, redirect;

  assign state = state_q;

  // Register 0 is hardwired, so it never creates a dependency.
  assign ex_match  = (ex_dst != 5'd0) &&
                     ((id_use_rs && (ex_dst == id_rs)) || (id_use_rt && (ex_dst == id_rt)));
  assign mem_match = (mem_dst != 5'd0) &&
                     ((id_use_rs && (mem_dst == id_rs)) || (id_use_rt && (mem_dst == id_rt)));

  assign hz = (ex_memRead && ex_match) ||
              (id_is_branch && ex_regWrite && ex_match) ||
              (id_is_branch && mem_memRead && mem_match);

  // Memory handshake: an access is presented by dmem_req and finishes on the
  // first cycle dmem_ready is high; req is only looked at while in RUN, and
  // the pipe holds on every cycle of an unfinished access.
  assign fz = ((state_q == RUN) && dmem_req && !dmem_ready) ||
              ((state_q == MEM_WAIT) && !dmem_ready);

  assign redirect = id_jump || (id_is_branch && id_branch_taken);

  always_comb begin
    state_d      = state_q;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    pipe_freeze  = 1'b0;

    case (state_q)
      RUN:      if (dmem_req && !dmem_ready) state_d = MEM_WAIT;
      MEM_WAIT: if (dmem_ready) state_d = RUN;
      default:  state_d = RUN;
    endcase

    if (fz) begin
      pipe_freeze = 1'b1;
      pc_write    = 1'b0;
      if_id_write = 1'b0;
    end else if (hz) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end else if (redirect) begin
      if_id_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // The FSM keeps waiting after a timeout; the error only flags it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt    <= '0;
      err_timeout <= 1'b0;
    end else begin
      if ((state_q == RUN) && (state_d == MEM_WAIT)) begin
        wait_cnt <= '0;
      end else if (state_q == MEM_WAIT) begin
        if (wait_cnt != WAIT_TOP) wait_cnt <= wait_cnt + WW'(1);
        if (wait_cnt >= WAIT_LAST) err_timeout <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      freeze_cnt <= '0;
    end else begin
      if (hz && !fz && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (if_id_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
      if (fz && (freeze_cnt != '1)) freeze_cnt <= freeze_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: a table of per-cycle vectors with expected controls,
// state and error, plus hand sequences for timeout and asynchronous reset.
module tb_hazard_ctrl;

  localparam int CNT_W = 16;

  // Control word order: {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze}
  localparam logic [4:0] ADV   = 5'b11000;
  localparam logic [4:0] STALL = 5'b00010;
  localparam logic [4:0] FLUSH = 5'b11100;
  localparam logic [4:0] FRZ   = 5'b00001;

  typedef struct {
    logic [4:0] rs, rt;
    logic       use_rs, use_rt, br, tk, jmp, exr, exw;
    logic [4:0] exd;
    logic       memr;
    logic [4:0] memd;
    logic       req, rdy;
    logic [4:0] ctl;
    logic       st;
    logic       er;
  } vec_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [4:0]       id_rs, id_rt, ex_dst, mem_dst;
  logic             id_use_rs, id_use_rt, id_is_branch, id_branch_taken, id_jump;
  logic             ex_memRead, ex_regWrite, mem_memRead, dmem_req, dmem_ready;
  logic             pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt, flush_cnt, freeze_cnt;
  logic             err_timeout;

  int check_cnt = 0;
  int pass_cnt  = 0;
  int exp_stall = 0, exp_flush = 0, exp_freeze = 0;
  logic [4:0] exp_q[$];
  vec_t vecs[20];

  hazard_ctrl #(.CNT_W(CNT_W), .WAIT_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_is_branch(id_is_branch), .id_branch_taken(id_branch_taken), .id_jump(id_jump),
    .ex_memRead(ex_memRead), .ex_regWrite(ex_regWrite), .ex_dst(ex_dst),
    .mem_memRead(mem_memRead), .mem_dst(mem_dst),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .pipe_freeze(pipe_freeze), .state(state),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .freeze_cnt(freeze_cnt),
    .err_timeout(err_timeout)
  );

  // Clock / reset
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt,
                              input logic use_rs, input logic use_rt,
                              input logic br, input logic tk, input logic jmp,
                              input logic exr, input logic exw, input logic [4:0] exd,
                              input logic memr, input logic [4:0] memd,
                              input logic req, input logic rdy,
                              input logic [4:0] ctl, input logic st, input logic er);
    vec_t v;
    v.rs = rs; v.rt = rt; v.use_rs = use_rs; v.use_rt = use_rt;
    v.br = br; v.tk = tk; v.jmp = jmp; v.exr = exr; v.exw = exw; v.exd = exd;
    v.memr = memr; v.memd = memd; v.req = req; v.rdy = rdy;
    v.ctl = ctl; v.st = st; v.er = er;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Driver
  task automatic drive(input vec_t v);
    id_rs = v.rs; id_rt = v.rt; id_use_rs = v.use_rs; id_use_rt = v.use_rt;
    id_is_branch = v.br; id_branch_taken = v.tk; id_jump = v.jmp;
    ex_memRead = v.exr; ex_regWrite = v.exw; ex_dst = v.exd;
    mem_memRead = v.memr; mem_dst = v.memd;
    dmem_req = v.req; dmem_ready = v.rdy;
  endtask

  task automatic check_regs(input string tag, input logic st, input logic er);
    check({tag, ".state"}, 32'(state), 32'(st));
    check({tag, ".err_timeout"}, 32'(err_timeout), 32'(er));
    check({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(exp_stall));
    check({tag, ".flush_cnt"}, 32'(flush_cnt), 32'(exp_flush));
    check({tag, ".freeze_cnt"}, 32'(freeze_cnt), 32'(exp_freeze));
  endtask

  // One cycle: called just after a rising edge, returns just after the next.
  task automatic step(input string tag, input vec_t v);
    logic [4:0] exp_ctl;
    drive(v);
    exp_q.push_back(v.ctl);
    @(negedge clk);
    exp_ctl = exp_q.pop_front();
    check({tag, ".ctl"}, 32'({pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze}),
          32'(exp_ctl));
    if (v.ctl[1]) exp_stall++;
    if (v.ctl[2]) exp_flush++;
    if (v.ctl[0]) exp_freeze++;
    @(posedge clk);
    #1;
    check_regs(tag, v.st, v.er);
  endtask

  initial begin
    vec_t idle;
    idle = mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,ADV,0,0);

    // rs  rt  urs urt br tk jmp exr exw exd memr memd req rdy ctl st er
    vecs[0]  = idle;
    vecs[1]  = mk(8,0, 1,0, 0,0,0, 1,1,8, 0,0, 0,0, STALL,0,0);  // load-use
    vecs[2]  = mk(8,0, 1,0, 0,0,0, 0,0,0, 1,8, 0,0, ADV,0,0);    // load now in MEM
    vecs[3]  = mk(9,0, 1,0, 1,1,0, 1,1,9, 0,0, 0,0, STALL,0,0);  // beq on lw in EX
    vecs[4]  = mk(9,0, 1,0, 1,1,0, 0,0,0, 1,9, 0,0, STALL,0,0);  // beq on lw in MEM
    vecs[5]  = mk(9,0, 1,0, 1,1,0, 0,0,0, 0,0, 0,0, FLUSH,0,0);  // branch resolves taken
    vecs[6]  = mk(0,0, 1,0, 0,0,0, 1,1,0, 0,0, 0,0, ADV,0,0);    // $0 never stalls
    vecs[7]  = mk(0,5, 0,0, 0,0,0, 1,1,5, 0,0, 0,0, ADV,0,0);    // rt unused
    vecs[8]  = mk(0,5, 0,1, 0,0,0, 1,1,5, 0,0, 0,0, STALL,0,0);  // rt load-use
    vecs[9]  = mk(1,3, 1,1, 1,0,0, 0,1,3, 0,0, 0,0, STALL,0,0);  // branch on ALU result
    vecs[10] = mk(1,3, 1,1, 0,0,0, 0,1,3, 0,0, 0,0, ADV,0,0);    // ALU result, forwarded
    vecs[11] = mk(0,0, 0,0, 0,0,1, 0,0,0, 0,0, 0,0, FLUSH,0,0);  // jump
    vecs[12] = mk(4,6, 1,1, 1,0,0, 0,1,7, 1,2, 0,0, ADV,0,0);    // branch not taken
    vecs[13] = mk(4,0, 1,0, 0,0,0, 0,0,0, 1,4, 0,0, ADV,0,0);    // load in MEM, no branch
    vecs[14] = mk(0,0, 0,0, 0,0,0, 0,0,0, 0,0, 1,1, ADV,0,0);    // single-cycle access
    vecs[15] = mk(8,0, 1,0, 0,0,0, 1,1,8, 0,0, 1,0, FRZ,1,0);    // miss, hz hidden
    vecs[16] = mk(8,0, 1,0, 0,0,0, 1,1,8, 0,0, 0,0, FRZ,1,0);    // req not resampled
    vecs[17] = mk(8,0, 1,0, 0,0,0, 1,1,8, 0,0, 0,0, FRZ,1,0);
    vecs[18] = mk(8,0, 1,0, 0,0,0, 1,1,8, 0,0, 0,1, STALL,0,0);  // freeze lifts, hz seen
    vecs[19] = idle;

    reset = 1'b1;
    drive(idle);
    @(negedge clk);
    check("reset.ctl", 32'({pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze}),
          32'(ADV));
    check_regs("reset", 1'b0, 1'b0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 20; i++) step($sformatf("vec%0d", i), vecs[i]);

    // Timeout: one RUN miss cycle then nine MEM_WAIT cycles; error on the 4th.
    step("to_entry", mk(0,0,0,0,0,0,0,0,0,0,0,0,1,0,FRZ,1,0));
    for (int j = 1; j <= 9; j++)
      step($sformatf("to_wait%0d", j), mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,FRZ,1,(j >= 4)));
    step("to_done", mk(0,0,0,0,0,0,0,0,0,0,0,0,0,1,ADV,0,1));
    step("to_sticky", mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,ADV,0,1));

    // Asynchronous reset while waiting with non-zero counters and error set.
    step("ar_entry", mk(0,0,0,0,0,0,0,0,0,0,0,0,1,0,FRZ,1,1));
    step("ar_wait", mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,FRZ,1,1));
    #2;
    reset = 1'b1;
    #1;
    exp_stall = 0; exp_flush = 0; exp_freeze = 0;
    check_regs("async_rst", 1'b0, 1'b0);
    drive(idle);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    step("post_rst", mk(8,0,1,0,0,0,0,1,1,8,0,0,0,0,STALL,0,0));
    step("post_rst2", mk(2,0,0,0,1,1,0,0,0,0,0,0,0,0,FLUSH,0,0));

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

  // Watchdog so the bench always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("%0d/%0d checks passed", pass_cnt, check_cnt + 1);
    $fatal(1);
  end

endmodule
